// File: rtl/vram_feeder_pkg.sv
// Shared types and constants for the VRAM pixel feeder.
package vram_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam logic FMT_RGB888 = 1'b0;
  localparam logic FMT_RGB565 = 1'b1;

  localparam int BYTES_888 = 3;
  localparam int BYTES_565 = 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Widen a 565 word to 888 by replicating the top bits into the new LSBs,
  // so full-scale codes map to 0xFF and zero stays zero.
  function automatic pixel_t expand_565(input logic [15:0] word);
    pixel_t p;
    p.r = {word[15:11], word[15:13]};
    p.g = {word[10:5],  word[10:9]};
    p.b = {word[4:0],   word[4:2]};
    return p;
  endfunction

endpackage

// File: rtl/vram_pixel_feeder_fifo.sv
// Small synchronous pixel FIFO with a flush that discards all entries.
module pixel_fifo
  import vram_feeder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk_sys,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   push,
  input  pixel_t din,
  input  logic   pop,
  output pixel_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  pixel_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign head      = r_mem[r_rd_ptr];

  // Storage array; contents past the pointers are don't-care, so no reset.
  always_ff @(posedge clk_sys) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; flush behaves like reset for the queue.
  always_ff @(posedge clk_sys) begin
    if (!rst_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/vram_pixel_feeder.sv
// Byte stream to VRAM pixel feeder: packs 888/565 bytes into pixels,
// buffers them, and writes them out while the VRAM is ready.
//
// state     | meaning
// ST_IDLE   | waiting for frame_start
// ST_ACTIVE | accepting bytes until target pixels are packed
// ST_DRAIN  | input closed, emptying FIFO until target pixels are written
module vram_pixel_feeder
  import vram_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 24
) (
  input  logic             clk_sys,
  input  logic             vga_reset_n,
  input  logic [15:0]      H,
  input  logic [15:0]      V,
  input  logic             fmt,
  input  logic             frame_start,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             vram_ready,
  output logic             vram_req,
  output logic [7:0]       r_vram_out,
  output logic [7:0]       g_vram_out,
  output logic [7:0]       b_vram_out,
  output logic [CNT_W-1:0] frame_pixels,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_abort
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_fmt;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_packed;
  logic [CNT_W-1:0] r_written;
  logic [1:0]       r_phase;
  logic [7:0]       r_byte0;
  logic [7:0]       r_byte1;
  logic             r_done;
  logic             r_abort;

  logic [CNT_W-1:0] w_target_new;
  logic             w_done_nxt;
  logic             w_abort_nxt;
  logic             w_accept;
  logic             w_last_byte;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  pixel_t           w_pix;
  pixel_t           w_head;

  // Full product first, then truncate to the counter width.
  assign w_target_new = CNT_W'(32'(H) * 32'(V));

  assign busy         = (r_state != ST_IDLE);
  assign s_ready      = (r_state == ST_ACTIVE) && (r_packed < r_target) && !w_full;
  assign w_accept     = s_valid && s_ready;
  assign w_last_byte  = (r_fmt == FMT_RGB565) ? (r_phase == 2'(BYTES_565 - 1))
                                              : (r_phase == 2'(BYTES_888 - 1));
  assign w_push       = w_accept && w_last_byte;
  assign vram_req     = !w_empty && vram_ready && busy;
  assign r_vram_out   = vram_req ? w_head.r : 8'h00;
  assign g_vram_out   = vram_req ? w_head.g : 8'h00;
  assign b_vram_out   = vram_req ? w_head.b : 8'h00;
  assign frame_pixels = r_written;
  assign frame_done   = r_done;
  assign frame_abort  = r_abort;

  // Pixel formed from stored bytes plus the byte arriving this cycle.
  always_comb begin
    w_pix = '0;
    if (r_fmt == FMT_RGB565) begin
      w_pix = expand_565({s_data, r_byte0});
    end else begin
      w_pix.r = r_byte0;
      w_pix.g = r_byte1;
      w_pix.b = s_data;
    end
  end

  // Next state and one-cycle status pulses; frame_start wins in any state.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_abort_nxt = 1'b0;
    if (frame_start) begin
      w_abort_nxt = busy;
      if (w_target_new == '0) begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = ST_ACTIVE;
      end
    end else begin
      case (r_state)
        ST_ACTIVE: if (r_packed == r_target) w_state_nxt = ST_DRAIN;
        ST_DRAIN: begin
          if (r_written == r_target) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // State, counters and partial-pixel byte capture.
  always_ff @(posedge clk_sys) begin
    if (!vga_reset_n) begin
      r_state   <= ST_IDLE;
      r_fmt     <= FMT_RGB888;
      r_target  <= '0;
      r_packed  <= '0;
      r_written <= '0;
      r_phase   <= '0;
      r_byte0   <= '0;
      r_byte1   <= '0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_abort <= w_abort_nxt;
      if (frame_start) begin
        r_fmt     <= fmt;
        r_target  <= w_target_new;
        r_packed  <= '0;
        r_written <= '0;
        r_phase   <= '0;
      end else begin
        if (vram_req) r_written <= r_written + CNT_W'(1);
        if (w_accept) begin
          if (w_last_byte) begin
            r_phase  <= '0;
            r_packed <= r_packed + CNT_W'(1);
          end else begin
            r_phase <= r_phase + 2'd1;
            if (r_phase == 2'd0) r_byte0 <= s_data;
            else                 r_byte1 <= s_data;
          end
        end
      end
    end
  end

  pixel_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .rst_n   (vga_reset_n),
    .flush   (frame_start),
    .push    (w_push),
    .din     (w_pix),
    .pop     (vram_req),
    .head    (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

endmodule

// File: tb/tb_vram_pixel_feeder.sv
// Bench for vram_pixel_feeder: queue-based reference model compared every
// cycle, plus directed scenarios with literal expected pixels.
module tb_vram_pixel_feeder;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 24;

  typedef logic [7:0] bq_t[$];

  logic             clk_sys = 1'b0;
  logic             vga_reset_n = 1'b0;
  logic [15:0]      H = '0;
  logic [15:0]      V = '0;
  logic             fmt = 1'b0;
  logic             frame_start = 1'b0;
  logic [7:0]       s_data = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic             vram_ready = 1'b0;
  logic             vram_req;
  logic [7:0]       r_vram_out;
  logic [7:0]       g_vram_out;
  logic [7:0]       b_vram_out;
  logic [CNT_W-1:0] frame_pixels;
  logic             busy;
  logic             frame_done;
  logic             frame_abort;

  always #5 clk_sys = ~clk_sys;

  vram_pixel_feeder #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk_sys      (clk_sys),
    .vga_reset_n  (vga_reset_n),
    .H            (H),
    .V            (V),
    .fmt          (fmt),
    .frame_start  (frame_start),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .vram_ready   (vram_ready),
    .vram_req     (vram_req),
    .r_vram_out   (r_vram_out),
    .g_vram_out   (g_vram_out),
    .b_vram_out   (b_vram_out),
    .frame_pixels (frame_pixels),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_abort  (frame_abort)
  );

  int  n_checks = 0;
  int  n_errors = 0;
  bit  chk_en   = 0;
  int  n_done   = 0;
  int  n_abort  = 0;
  int  g_acc    = 0;
  logic [23:0] dut_log[$];

  // Reference model: frame in progress as plain counts and queues.
  int              m_mode    = 0;   // 0 idle, 1 taking bytes, 2 draining
  bit              m_fmt     = 0;
  longint unsigned m_target  = 0;
  longint unsigned m_packed  = 0;
  longint unsigned m_written = 0;
  logic [23:0]     m_q[$];
  logic [7:0]      m_part[$];
  bit              m_done    = 0;
  bit              m_abort   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] make_pixel(input bit f, input logic [7:0] b0,
                                             input logic [7:0] b1, input logic [7:0] b2);
    int w, r5, g6, b5;
    if (!f) return {b0, b1, b2};
    w  = int'(b1) * 256 + int'(b0);
    r5 = w / 2048;
    g6 = (w / 32) % 64;
    b5 = w % 32;
    return 24'((r5 * 8 + r5 / 4) * 65536 + (g6 * 4 + g6 / 16) * 256 + (b5 * 8 + b5 / 4));
  endfunction

  function automatic bit exp_ready();
    return (m_mode == 1) && (m_packed < m_target) && (m_q.size() < FIFO_DEPTH);
  endfunction

  function automatic bit exp_req();
    return (m_q.size() > 0) && vram_ready && (m_mode != 0);
  endfunction

  // Advance the model on each rising edge using the inputs present there.
  always @(posedge clk_sys) begin : model
    bit acc, pop, was_full, was_done;
    longint unsigned p;
    if (!vga_reset_n) begin
      m_mode = 0; m_fmt = 0; m_target = 0; m_packed = 0; m_written = 0;
      m_q.delete(); m_part.delete(); m_done = 0; m_abort = 0;
    end else begin
      acc      = s_valid && exp_ready();
      pop      = exp_req();
      was_full = (m_packed == m_target);
      was_done = (m_written == m_target);
      m_done   = 0;
      m_abort  = 0;
      if (frame_start) begin
        m_abort = (m_mode != 0);
        m_q.delete(); m_part.delete();
        m_fmt    = fmt;
        p        = longint'(H) * longint'(V);
        m_target = p % (64'd1 << CNT_W);
        m_packed = 0; m_written = 0;
        if (m_target == 0) begin m_mode = 0; m_done = 1; end
        else m_mode = 1;
      end else begin
        if (pop) begin
          void'(m_q.pop_front());
          m_written++;
        end
        if (acc) begin
          m_part.push_back(s_data);
          if (m_part.size() == (m_fmt ? 2 : 3)) begin
            if (m_fmt) m_q.push_back(make_pixel(1'b1, m_part[0], m_part[1], 8'h00));
            else       m_q.push_back(make_pixel(1'b0, m_part[0], m_part[1], m_part[2]));
            m_part.delete();
            m_packed++;
          end
        end
        if (m_mode == 1 && was_full) m_mode = 2;
        else if (m_mode == 2 && was_done) begin m_mode = 0; m_done = 1; end
      end
    end
  end

  // Compare DUT outputs with the model mid-cycle, and log VRAM writes.
  always @(negedge clk_sys) begin : compare
    bit er;
    if (chk_en) begin
      er = exp_req();
      chk("s_ready", s_ready, exp_ready());
      chk("vram_req", vram_req, er);
      chk("rgb", {r_vram_out, g_vram_out, b_vram_out}, er ? m_q[0] : 24'h0);
      chk("frame_pixels", frame_pixels, m_written[CNT_W-1:0]);
      chk("busy", busy, m_mode != 0);
      chk("frame_done", frame_done, m_done);
      chk("frame_abort", frame_abort, m_abort);
      if (vram_req)    dut_log.push_back({r_vram_out, g_vram_out, b_vram_out});
      if (frame_done)  n_done++;
      if (frame_abort) n_abort++;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_frame(input int h, input int v, input bit f);
    H = 16'(h); V = 16'(v); fmt = f; s_valid = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_bytes(input bq_t bq, input int budget, input bit rnd);
    int cyc = 0;
    bit acc;
    g_acc = 0;
    while (g_acc < bq.size() && cyc < budget) begin
      s_data  = bq[g_acc];
      s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rnd) vram_ready = ($urandom_range(0, 2) != 0);
      acc = s_valid && s_ready;
      tick();
      if (acc) g_acc++;
      cyc++;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, input int budget);
    int c = 0;
    while (n_done <= start && c < budget) begin
      tick();
      c++;
    end
    chk("frame_done_seen", n_done > start, 1);
  endtask

  initial begin : global_timeout
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got %0d checks", n_checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    bq_t bq;
    int  d0;
    vga_reset_n = 1'b0;
    tick();
    chk_en = 1;
    tick();
    chk("reset_outputs", {s_ready, vram_req, r_vram_out, g_vram_out, b_vram_out,
                          frame_pixels, busy, frame_done, frame_abort}, 0);
    vga_reset_n = 1'b1;
    tick();

    // RGB888 4x2 frame, pixel i = {i, i+1, i+2}
    vram_ready = 1'b1;
    dut_log.delete();
    bq.delete();
    for (int i = 0; i < 8; i++) begin
      bq.push_back(8'(i)); bq.push_back(8'(i + 1)); bq.push_back(8'(i + 2));
    end
    d0 = n_done;
    start_frame(4, 2, 1'b0);
    send_bytes(bq, 200, 1'b0);
    wait_done(d0, 50);
    tick(); tick();
    chk("rgb888_count", dut_log.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("rgb888_px", dut_log[i], 24'(i * 65536 + (i + 1) * 256 + (i + 2)));
    chk("rgb888_frame_pixels", frame_pixels, 8);
    chk("rgb888_done_once", n_done - d0, 1);
    chk("rgb888_busy_low", busy, 0);

    // RGB565 expansion
    dut_log.delete();
    d0 = n_done;
    start_frame(1, 1, 1'b1);
    bq = '{8'h1F, 8'hF8};
    send_bytes(bq, 20, 1'b0);
    wait_done(d0, 20);
    d0 = n_done;
    start_frame(1, 1, 1'b1);
    bq = '{8'hE0, 8'h07};
    send_bytes(bq, 20, 1'b0);
    wait_done(d0, 20);
    chk("rgb565_magenta", dut_log[0], 24'hFF00FF);
    chk("rgb565_green", dut_log[1], 24'h00FF00);

    // Backpressure: 8-pixel frame with VRAM stalled for 20 cycles
    dut_log.delete();
    vram_ready = 1'b0;
    bq.delete();
    for (int i = 0; i < 8; i++) begin
      bq.push_back(8'(8'h10 + i)); bq.push_back(8'(8'h20 + i)); bq.push_back(8'(8'h30 + i));
    end
    d0 = n_done;
    start_frame(8, 1, 1'b0);
    fork
      send_bytes(bq, 300, 1'b0);
      begin
        repeat (20) tick();
        #2;
        chk("bp_bytes_taken", g_acc, FIFO_DEPTH * 3);
        chk("bp_s_ready", s_ready, 0);
        chk("bp_vram_req", vram_req, 0);
        chk("bp_frame_pixels", frame_pixels, 0);
        vram_ready = 1'b1;
      end
    join
    wait_done(d0, 50);
    chk("bp_count", dut_log.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("bp_px", dut_log[i], 24'((16 + i) * 65536 + (32 + i) * 256 + (48 + i)));

    // Frame boundary: 2x1 RGB888 offered 9 bytes
    d0 = n_done;
    start_frame(2, 1, 1'b0);
    bq.delete();
    for (int i = 0; i < 9; i++) bq.push_back(8'(8'hA0 + i));
    send_bytes(bq, 30, 1'b0);
    chk("boundary_bytes", g_acc, 6);
    chk("boundary_s_ready", s_ready, 0);
    wait_done(d0, 20);
    repeat (3) tick();
    chk("boundary_done_once", n_done - d0, 1);

    // Abort after 5 bytes of a 4x1 RGB888 frame, restart as 2x1 RGB565
    dut_log.delete();
    start_frame(4, 1, 1'b0);
    bq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_bytes(bq, 20, 1'b0);
    d0 = n_done;
    start_frame(2, 1, 1'b1);
    chk("abort_pulse", frame_abort, 1);
    chk("abort_pixels_cleared", frame_pixels, 0);
    bq = '{8'h1F, 8'hF8, 8'hE0, 8'h07};
    send_bytes(bq, 20, 1'b0);
    wait_done(d0, 20);
    chk("abort_count", dut_log.size(), 3);
    chk("abort_old_px", dut_log[0], 24'h000102);
    chk("abort_new_px0", dut_log[1], 24'hFF00FF);
    chk("abort_new_px1", dut_log[2], 24'h00FF00);
    chk("abort_new_frame_pixels", frame_pixels, 2);

    // Reset while draining a full FIFO
    vram_ready = 1'b0;
    start_frame(4, 1, 1'b0);
    bq.delete();
    for (int i = 0; i < 12; i++) bq.push_back(8'(8'h50 + i));
    send_bytes(bq, 40, 1'b0);
    tick(); tick();
    chk("drain_busy", busy, 1);
    vga_reset_n = 1'b0;
    vram_ready  = 1'b1;
    tick();
    chk("drain_reset_outputs", {s_ready, vram_req, r_vram_out, g_vram_out, b_vram_out,
                                frame_pixels, busy, frame_done, frame_abort}, 0);
    vga_reset_n = 1'b1;
    tick();

    // Zero-size frame
    start_frame(0, 5, 1'b0);
    chk("zero_done", frame_done, 1);
    chk("zero_busy", busy, 0);
    tick();
    chk("zero_done_single", frame_done, 0);
    chk("zero_no_req", vram_req, 0);

    // Random frames with random valid and VRAM stalls
    for (int f = 0; f < 8; f++) begin
      int  h, v;
      bit  fm;
      h  = $urandom_range(1, 5);
      v  = $urandom_range(1, 3);
      fm = 1'($urandom_range(0, 1));
      bq.delete();
      for (int i = 0; i < h * v * (fm ? 2 : 3); i++) bq.push_back(8'($urandom_range(0, 255)));
      d0 = n_done;
      start_frame(h, v, fm);
      send_bytes(bq, 2000, 1'b1);
      vram_ready = 1'b1;
      wait_done(d0, 100);
      tick();
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
